// File: rtl/fifo_ram_ctrl_if.sv
// rtl/fifo_ram_ctrl_if.sv - producer/consumer bundle for fifo_ram_ctrl
interface fifo_ram_ctrl_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   fifo_cnt;
  logic [1:0]            error;

  // Producer/consumer side: issues requests, observes data and flags
  modport master (
    output wr_en, data_in, rd_en,
    input  data_out, valid_out, full, empty, almost_full, almost_empty,
           fifo_cnt, error
  );

  // FIFO side
  modport slave (
    input  wr_en, data_in, rd_en,
    output data_out, valid_out, full, empty, almost_full, almost_empty,
           fifo_cnt, error
  );
endinterface

// File: rtl/fifo_ram_ctrl.sv
// rtl/fifo_ram_ctrl.sv - synchronous FIFO with flags and registered read; FIFO_ERR_EN enables sticky errors
module fifo_ram_ctrl #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_THRESH  = 3,
  parameter int AE_THRESH  = 1
) (
  input  logic           clk,
  input  logic           reset_L,
  fifo_ram_ctrl_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_LVL   = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   AE_LVL   = (ADDR_WIDTH + 1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = (ADDR_WIDTH)'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  full_w, empty_w;
  logic                  wr_acc, rd_acc;

  // Flags come straight from the registered occupancy so they only move on an edge or reset
  assign full_w           = (cnt_q == CNT_FULL);
  assign empty_w          = (cnt_q == '0);
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (cnt_q >= AF_LVL);
  assign bus.almost_empty = (cnt_q <= AE_LVL);
  assign bus.fifo_cnt     = cnt_q;
  assign bus.data_out     = dout_q;
  assign bus.valid_out    = valid_q;

  // Acceptance decisions use the pre-edge flags only, so there is no fall-through path
  always_comb begin
    wr_acc   = bus.wr_en && !full_w;
    rd_acc   = bus.rd_en && !empty_w;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    valid_d  = 1'b0;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      dout_d   = mem_q[rd_ptr_q];
      valid_d  = 1'b1;
    end
    if (wr_acc && !rd_acc) cnt_d = cnt_q + CNT_ONE;
    if (rd_acc && !wr_acc) cnt_d = cnt_q - CNT_ONE;
  end

  // Pointer, occupancy and read-port registers; reset discards stored words via the pointers
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
    end
  end

  // Storage array is not reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.data_in;
  end

`ifdef FIFO_ERR_EN
  logic [1:0] err_q, err_d;

  // Sticky overflow (bit0) and underflow (bit1), held until reset
  always_comb begin
    err_d = err_q | {bus.rd_en && empty_w, bus.wr_en && full_w};
  end

  // Error register
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) err_q <= 2'b00;
    else          err_q <= err_d;
  end

  assign bus.error = err_q;
`else
  assign bus.error = 2'b00;
`endif
endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// tb/tb_fifo_ram_ctrl.sv - self-checking bench for fifo_ram_ctrl against a queue model
module tb_fifo_ram_ctrl;
  localparam int DW = 6;
  localparam int AW = 2;
  localparam int DEPTH = 4;
  localparam int AF = 3;
  localparam int AE = 1;
`ifdef FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_L;
  int   checks = 0;
  int   errors = 0;

  fifo_ram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_valid;
  logic [1:0]    m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_err   = 2'b00;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check({tag, ".cnt"},   32'(bus.fifo_cnt),     32'(n));
    check({tag, ".full"},  32'(bus.full),         32'(n == DEPTH));
    check({tag, ".empty"}, 32'(bus.empty),        32'(n == 0));
    check({tag, ".af"},    32'(bus.almost_full),  32'(n >= AF));
    check({tag, ".ae"},    32'(bus.almost_empty), 32'(n <= AE));
    check({tag, ".valid"}, 32'(bus.valid_out),    32'(m_valid));
    check({tag, ".dout"},  32'(bus.data_out),     32'(m_dout));
    check({tag, ".err"},   32'(bus.error),        32'(ERR_EN ? m_err : 2'b00));
  endtask

  // One clock cycle of requests, model update from the pre-edge occupancy, then check
  task automatic step(input string tag, input logic wr, input logic [DW-1:0] din, input logic rd);
    bit wr_ok, rd_ok;
    bus.wr_en   = wr;
    bus.data_in = din;
    bus.rd_en   = rd;
    wr_ok = wr && (q.size() < DEPTH);
    rd_ok = rd && (q.size() > 0);
    if (wr && q.size() == DEPTH) m_err[0] = 1'b1;
    if (rd && q.size() == 0)     m_err[1] = 1'b1;
    @(posedge clk);
    m_valid = rd_ok;
    if (rd_ok) m_dout = q.pop_front();
    if (wr_ok) q.push_back(din);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check_all(tag);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.data_in = '0;
    reset_L     = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    #1;
    check_all("reset");

    // Fill to full
    for (int i = 1; i <= 4; i++) step("fill", 1'b1, DW'(i), 1'b0);

    // Overflow attempt
    step("ovf", 1'b1, 6'h3F, 1'b0);

    // Drain: expect 1..4
    for (int i = 1; i <= 4; i++) begin
      step("drain", 1'b0, '0, 1'b1);
      check("drain.word", 32'(bus.data_out), 32'(i));
    end

    // Underflow attempt; data_out must hold 0x04
    step("udf", 1'b0, '0, 1'b1);
    check("udf.hold", 32'(bus.data_out), 32'h04);

    // Simultaneous read/write streaming across pointer wrap
    step("sim0", 1'b1, 6'h0A, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step("sim", 1'b1, DW'(6'h10 + i), 1'b1);
      check("sim.word", 32'(bus.data_out), (i == 0) ? 32'h0A : 32'(6'h10 + i - 1));
    end

    // Two words held, then asynchronous reset mid-cycle
    step("pre_rst", 1'b1, 6'h2A, 1'b0);
    check("pre_rst.cnt", 32'(bus.fifo_cnt), 32'd2);
    #2;
    reset_L = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    #2;
    reset_L = 1'b1;
    #1;
    check_all("rst_rel");

    // Randomized traffic, biased toward both full and empty corners
    for (int i = 0; i < 300; i++) begin
      int bias;
      bias = (i / 50) % 2;
      step("rand", ($urandom_range(99) < (bias ? 75 : 35)),
           DW'($urandom), ($urandom_range(99) < (bias ? 35 : 75)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
